// File: rtl/tx_port_arbiter_if.sv
// Requester-side and tx-side signals of one tx_port_arbiter; the arbiter takes the slave modport,
// the router buffers / tx wrapper side takes master.
`ifndef PAYLOAD_SIZE
`define PAYLOAD_SIZE 8
`endif
`ifndef ADDR_BITS
`define ADDR_BITS 8
`endif
interface tx_port_arbiter_if #(
    parameter int N_REQ  = 5,
    parameter int FLIT_W = `PAYLOAD_SIZE + `ADDR_BITS,
    parameter int IDX_W  = $clog2(N_REQ)
);
    logic [N_REQ-1:0]        req_vec;
    logic [N_REQ*FLIT_W-1:0] data_vec;
    logic [N_REQ-1:0]        ack_vec;
    logic                    tx_req;
    logic [FLIT_W-1:0]       tx_data;
    logic                    tx_busy;
    logic                    tx_active;
    logic [IDX_W-1:0]        owner;
    logic                    arb_busy;

    modport master (
        output req_vec,
        output data_vec,
        output tx_busy,
        output tx_active,
        input  ack_vec,
        input  tx_req,
        input  tx_data,
        input  owner,
        input  arb_busy
    );

    modport slave (
        input  req_vec,
        input  data_vec,
        input  tx_busy,
        input  tx_active,
        output ack_vec,
        output tx_req,
        output tx_data,
        output owner,
        output arb_busy
    );
endinterface

// File: rtl/tx_port_arbiter.sv
// Shares one serial tx among N_REQ flit sources; round-robin, or lowest-index-wins with TX_ARB_FIXED_PRIORITY_EN.
// Request sample to ack is 3 cycles minimum; tx_busy holds off issue and tx_req is held until tx_active is seen.
`ifndef PAYLOAD_SIZE
`define PAYLOAD_SIZE 8
`endif
`ifndef ADDR_BITS
`define ADDR_BITS 8
`endif
module tx_port_arbiter #(
    parameter int N_REQ  = 5,
    parameter int FLIT_W = `PAYLOAD_SIZE + `ADDR_BITS,
    parameter int IDX_W  = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             reset,
    tx_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    localparam logic [IDX_W:0]   N_REQ_W  = (IDX_W + 1)'(N_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic               tx_req_q, tx_req_d;
    logic [FLIT_W-1:0]  tx_data_q, tx_data_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic               arb_busy_q, arb_busy_d;

    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   req_rot;
    logic [IDX_W-1:0]   rot_off;
    logic [IDX_W:0]     win_sum;
    logic [IDX_W-1:0]   winner;
    logic               winner_vld;
    logic [FLIT_W-1:0]  winner_flit;

    // Rotating the doubled request vector by the pointer turns the wrap-around
    // search into a plain lowest-set-bit search.
    assign req_dbl = {bus.req_vec, bus.req_vec};
    assign req_rot = req_dbl[ptr_q +: N_REQ];

    always_comb begin
        rot_off = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                rot_off = IDX_W'(k);
            end
        end
    end

    assign win_sum     = {1'b0, ptr_q} + {1'b0, rot_off};
    assign winner      = (win_sum >= N_REQ_W) ? IDX_W'(win_sum - N_REQ_W) : win_sum[IDX_W-1:0];
    assign winner_vld  = |bus.req_vec;
    assign winner_flit = bus.data_vec[winner*FLIT_W +: FLIT_W];

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        tx_req_d  = tx_req_q;
        tx_data_d = tx_data_q;
        ack_d     = '0;

        unique case (state_q)
            IDLE: begin
                if (winner_vld && !bus.tx_busy) begin
                    owner_d   = winner;
                    tx_data_d = winner_flit;
                    tx_req_d  = 1'b1;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                // The latched flit is committed: a requester dropping req here
                // still gets its flit sent and acked.
                if (bus.tx_active) begin
                    tx_req_d = 1'b0;
                    ack_d    = N_REQ'(1) << owner_q;
`ifdef TX_ARB_FIXED_PRIORITY_EN
                    ptr_d    = '0;
`else
                    ptr_d    = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
`endif
                    state_d  = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_active) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        arb_busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            owner_q    <= '0;
            tx_req_q   <= 1'b0;
            tx_data_q  <= '0;
            ack_q      <= '0;
            arb_busy_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            tx_req_q   <= tx_req_d;
            tx_data_q  <= tx_data_d;
            ack_q      <= ack_d;
            arb_busy_q <= arb_busy_d;
        end
    end

    assign bus.ack_vec  = ack_q;
    assign bus.tx_req   = tx_req_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.owner    = owner_q;
    assign bus.arb_busy = arb_busy_q;

`ifndef SYNTHESIS
    ack_onehot_a: assert property (@(posedge clk) disable iff (reset) $onehot0(ack_q));
    req_only_in_issue_a: assert property (@(posedge clk) disable iff (reset) tx_req_q |-> (state_q == ISSUE));
`endif

endmodule
